// File: rtl/mask_apply_pkg.sv
// mask_apply_pkg: shared pixel type and constants for the mask apply stage
package mask_apply_pkg;
  typedef logic [23:0] pixel_t;
  localparam pixel_t DEFAULT_BG_COLOR = 24'h000000;
  localparam int FG_COUNT_W = 32;
endpackage

// File: rtl/mask_apply_pixel_fifo.sv
// pixel_fifo: pixel buffer holding pixels while their masks are in flight
// Ports: clk/rst_n (async active-low), push/din write side, pop read side,
// dout combinational head, level occupancy, full/empty status.
// Pushes on a full FIFO are taken only when a pop frees a slot in the same
// cycle; pops on an empty FIFO are ignored, so a same-cycle push into an
// empty FIFO is never visible to the pop.
module pixel_fifo
  import mask_apply_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_WIDTH-1:0]    din,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic push_ok, pop_ok;
  assign empty   = wr_ptr == rd_ptr;
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/mask_apply.sv
// mask_apply: pairs ordered mask bits with buffered pixels and emits the
// background-removed pixel one cycle after each mask.
// Ports: i_CLK, i_RSTn (async active-low), i_DATA/i_DATA_VALID pixel stream,
// i_MASK/i_MASK_VALID mask stream, i_CLR clears sticky flags (and counter),
// o_DATA/o_VALID masked pixel, o_LEVEL FIFO occupancy, o_OVERFLOW and
// o_UNDERFLOW sticky error flags.
// Optional: define MASK_APPLY_FG_COUNT_EN to add o_FG_COUNT, a saturating
// count of foreground output pixels.
module mask_apply
  import mask_apply_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH = 16,
  parameter logic [DATA_WIDTH-1:0] BG_COLOR = DATA_WIDTH'(DEFAULT_BG_COLOR)
) (
  input  logic                    i_CLK,
  input  logic                    i_RSTn,
  input  logic [DATA_WIDTH-1:0]   i_DATA,
  input  logic                    i_DATA_VALID,
  input  logic                    i_MASK,
  input  logic                    i_MASK_VALID,
  input  logic                    i_CLR,
`ifdef MASK_APPLY_FG_COUNT_EN
  output logic [FG_COUNT_W-1:0]   o_FG_COUNT,
`endif
  output logic [DATA_WIDTH-1:0]   o_DATA,
  output logic                    o_VALID,
  output logic [$clog2(DEPTH):0]  o_LEVEL,
  output logic                    o_OVERFLOW,
  output logic                    o_UNDERFLOW
);
  logic [DATA_WIDTH-1:0] head;
  logic full, empty, pop_ok, ovf_set, udf_set;
  pixel_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (i_CLK),
    .rst_n (i_RSTn),
    .push  (i_DATA_VALID),
    .pop   (i_MASK_VALID),
    .din   (i_DATA),
    .dout  (head),
    .level (o_LEVEL),
    .full  (full),
    .empty (empty)
  );
  assign pop_ok  = i_MASK_VALID && !empty;
  assign udf_set = i_MASK_VALID && empty;
  // a full FIFO still accepts the pixel when a pop frees a slot this cycle
  assign ovf_set = i_DATA_VALID && full && !pop_ok;
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      o_DATA      <= '0;
      o_VALID     <= 1'b0;
      o_OVERFLOW  <= 1'b0;
      o_UNDERFLOW <= 1'b0;
    end else begin
      o_VALID     <= pop_ok;
      o_DATA      <= pop_ok ? (i_MASK ? head : BG_COLOR) : o_DATA;
      o_OVERFLOW  <= ovf_set || (o_OVERFLOW && !i_CLR);
      o_UNDERFLOW <= udf_set || (o_UNDERFLOW && !i_CLR);
    end
  end
`ifdef MASK_APPLY_FG_COUNT_EN
  logic fg_inc;
  assign fg_inc = pop_ok && i_MASK;
  // increment takes priority over clear; the count sticks at all-ones
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) o_FG_COUNT <= '0;
    else o_FG_COUNT <= fg_inc ? o_FG_COUNT + FG_COUNT_W'(!(&o_FG_COUNT)) : i_CLR ? '0 : o_FG_COUNT;
  end
`endif
endmodule

// File: tb/tb_mask_apply.sv
// tb_mask_apply: scoreboard bench for mask_apply
module tb_mask_apply;
  localparam int DEPTH = 16;
  logic clk = 0, rst_n = 0;
  logic [23:0] i_data = 0;
  logic i_data_valid = 0, i_mask = 0, i_mask_valid = 0, i_clr = 0;
  logic [23:0] o_data;
  logic o_valid, o_overflow, o_underflow;
  logic [4:0] o_level;
`ifdef MASK_APPLY_FG_COUNT_EN
  logic [31:0] o_fg_count;
`endif
  int n_checks = 0, n_fail = 0;
  logic [23:0] mq[$];
  logic [23:0] sb[$];
  logic ovf_m = 0, udf_m = 0;

  mask_apply #(.DATA_WIDTH(24), .DEPTH(DEPTH), .BG_COLOR(24'h000000)) dut (
    .i_CLK(clk), .i_RSTn(rst_n), .i_DATA(i_data), .i_DATA_VALID(i_data_valid),
    .i_MASK(i_mask), .i_MASK_VALID(i_mask_valid), .i_CLR(i_clr),
`ifdef MASK_APPLY_FG_COUNT_EN
    .o_FG_COUNT(o_fg_count),
`endif
    .o_DATA(o_data), .o_VALID(o_valid), .o_LEVEL(o_level),
    .o_OVERFLOW(o_overflow), .o_UNDERFLOW(o_underflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && o_valid) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: got o_DATA=%h, expected no output", o_data);
      end else begin
        logic [23:0] e;
        e = sb.pop_front();
        if (o_data !== e) begin
          n_fail++;
          $display("FAIL out_data: got %h, expected %h", o_data, e);
        end
      end
    end
  end

  task automatic drive(input logic dv, input logic [23:0] d, input logic mv, input logic m, input logic clr);
    logic popped;
    i_data_valid = dv; i_data = d; i_mask_valid = mv; i_mask = m; i_clr = clr;
    popped = mv && mq.size() > 0;
    if (clr) begin ovf_m = 0; udf_m = 0; end
    if (mv && !popped) udf_m = 1;
    if (popped) begin
      logic [23:0] p;
      p = mq.pop_front();
      sb.push_back(m ? p : 24'h000000);
    end
    if (dv) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else ovf_m = 1;
    end
    @(posedge clk); #1;
    i_data_valid = 0; i_mask_valid = 0; i_mask = 0; i_clr = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
  endtask

  task automatic check_state(input string name);
    n_checks++;
    if (o_level !== 5'(mq.size()) || o_overflow !== ovf_m || o_underflow !== udf_m) begin
      n_fail++;
      $display("FAIL %s: got level=%0d ovf=%b udf=%b, expected level=%0d ovf=%b udf=%b",
               name, o_level, o_overflow, o_underflow, mq.size(), ovf_m, udf_m);
    end
  endtask

  task automatic check_drained(input string name);
    idle(2);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s: got %0d outputs missing, expected 0", name, sb.size());
    end
    check_state(name);
  endtask

  task automatic test_reset;
    #2;
    n_checks++;
    if (o_data !== 0 || o_valid !== 0 || o_level !== 0 || o_overflow !== 0 || o_underflow !== 0) begin
      n_fail++;
      $display("FAIL reset: got data=%h valid=%b level=%0d ovf=%b udf=%b, expected all 0",
               o_data, o_valid, o_level, o_overflow, o_underflow);
    end
    @(posedge clk); #1 rst_n = 1;
    idle(1);
    check_state("reset_idle");
  endtask

  task automatic test_basic;
    logic [23:0] px [4];
    px = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
    for (int i = 0; i < 4; i++) drive(1, px[i], 0, 0, 0);
    check_state("basic_peak");
    idle(3);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, ~i[0], 0);
    check_drained("basic_drain");
  endtask

  task automatic test_overflow;
    for (int i = 1; i <= 20; i++) begin
      drive(1, 24'h010000 + 24'(i), 0, 0, 0);
      if (i == 16) check_state("ovf_at16");
      if (i == 17) check_state("ovf_at17");
    end
    check_state("ovf_full");
    for (int i = 0; i < 16; i++) drive(0, 0, 1, 1, 0);
    check_drained("ovf_drain");
    drive(0, 0, 0, 0, 1);
    check_state("ovf_clr");
  endtask

  task automatic test_underflow;
    drive(0, 0, 1, 1, 0);
    check_state("udf_set");
    drive(0, 0, 0, 0, 1);
    check_state("udf_clr");
    drive(0, 0, 1, 1, 1);
    check_state("udf_set_wins_clr");
    drive(1, 24'h0F0F0F, 1, 1, 1);
    check_state("udf_empty_push_pop");
    drive(0, 0, 1, 1, 0);
    check_drained("udf_drain");
    drive(0, 0, 0, 0, 1);
    check_state("udf_clr2");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 16; i++) drive(1, 24'h200000 + 24'(i), 0, 0, 0);
    check_state("b2b_full");
    for (int i = 0; i < 32; i++) begin
      drive(1, 24'h300000 + 24'(i), 1, 1'($urandom_range(0, 1)), 0);
      check_state("b2b_steady");
    end
    for (int i = 0; i < 16; i++) drive(0, 0, 1, 1, 0);
    check_drained("b2b_drain");
  endtask

  task automatic test_reset_midstream;
    for (int i = 0; i < 6; i++) drive(1, 24'h500000 + 24'(i), 0, 0, 0);
    drive(0, 0, 1, 1, 0);
    rst_n = 0;
    #1;
    n_checks++;
    if (o_valid !== 0 || o_level !== 0) begin
      n_fail++;
      $display("FAIL reset_mid: got valid=%b level=%0d, expected valid=0 level=0", o_valid, o_level);
    end
    mq.delete(); sb.delete(); ovf_m = 0; udf_m = 0;
    @(posedge clk); #1 rst_n = 1;
    drive(1, 24'hDEADBE, 0, 0, 0);
    drive(0, 0, 1, 1, 0);
    check_drained("reset_mid_after");
  endtask

`ifdef MASK_APPLY_FG_COUNT_EN
  task automatic test_fg_count;
    logic [9:0] pat;
    pat = 10'b1010101011;
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) drive(1, 24'h600000 + 24'(i), 0, 0, 0);
    for (int i = 9; i >= 0; i--) drive(0, 0, 1, pat[i], 0);
    check_drained("fg_drain");
    n_checks++;
    if (o_fg_count !== 32'd6) begin
      n_fail++;
      $display("FAIL fg_count: got %0d, expected 6", o_fg_count);
    end
    drive(0, 0, 0, 0, 1);
    n_checks++;
    if (o_fg_count !== 32'd0) begin
      n_fail++;
      $display("FAIL fg_clr: got %0d, expected 0", o_fg_count);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_overflow;
    test_underflow;
    test_back_to_back;
    test_reset_midstream;
`ifdef MASK_APPLY_FG_COUNT_EN
    test_fg_count;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
